// File: rtl/control_unit_multicycle_if.sv
// Signal bundle between the multicycle RV64I control FSM (master) and the
// datapath/memory side (slave): decode fields and flags in, strobes and selects out.
interface control_unit_multicycle_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero;
  logic             lt;
  logic             ltu;
  logic             mem_ready;

  logic             mem_req;
  logic             memWrite;
  logic [2:0]       memType;
  logic             adrSrc;
  logic             irWrite;
  logic             pcWrite;
  logic             regWrite;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [3:0]       ALUControl;
  logic             ALU32;
  logic [2:0]       immSrc;
  logic [1:0]       resultSrc;
  logic             ecall;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7, zero, lt, ltu, mem_ready,
    output mem_req, memWrite, memType, adrSrc, irWrite, pcWrite, regWrite,
           ALUSrcA, ALUSrcB, ALUControl, ALU32, immSrc, resultSrc,
           ecall, trap, trap_cause, instret
  );

  modport slave (
    output op, funct3, funct7, zero, lt, ltu, mem_ready,
    input  mem_req, memWrite, memType, adrSrc, irWrite, pcWrite, regWrite,
           ALUSrcA, ALUSrcB, ALUControl, ALU32, immSrc, resultSrc,
           ecall, trap, trap_cause, instret
  );
endinterface

// File: rtl/control_unit_multicycle.sv
// Multi-cycle RV64I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath with one memory port, with handshake timeout and sticky trap.
module control_unit_multicycle #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int MEM_TIMEOUT   = 16,
  parameter bit SUPPORT_W     = 1'b1,
  parameter int CNT_W         = 32
) (
  input logic                       clk,
  input logic                       reset,
  control_unit_multicycle_if.master bus
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALU    = 2'b00;
  localparam logic [1:0] RES_ALUOUT = 2'b01;
  localparam logic [1:0] RES_MEM    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

  localparam logic [2:0] MEMTYPE_FETCH = 3'b110;

  // The wait counter only ever holds 0..MEM_TIMEOUT-1; the last value is the final chance.
  localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR2,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic       memReady;
  logic       isWOp;
  logic       isImmOp;
  logic       isEcall;
  logic       branchTaken;
  logic       illegal;
  logic [2:0] immType;

  assign memReady = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign isWOp    = SUPPORT_W && ((bus.op == OPC_OP_32) || (bus.op == OPC_OP_IMM_32));
  assign isImmOp  = (bus.op == OPC_OP_IMM) || (bus.op == OPC_OP_IMM_32);
  assign isEcall  = (bus.op == OPC_SYSTEM) && (bus.funct3 == 3'b000);

  always_comb begin
    case (bus.op)
      OPC_STORE:          immType = IMM_S;
      OPC_BRANCH:         immType = IMM_B;
      OPC_JAL:            immType = IMM_J;
      OPC_LUI, OPC_AUIPC: immType = IMM_U;
      default:            immType = IMM_I;
    endcase
  end

  always_comb begin
    case (bus.funct3)
      3'b000:  branchTaken = bus.zero;
      3'b001:  branchTaken = ~bus.zero;
      3'b100:  branchTaken = bus.lt;
      3'b101:  branchTaken = ~bus.lt;
      3'b110:  branchTaken = bus.ltu;
      3'b111:  branchTaken = ~bus.ltu;
      default: branchTaken = 1'b0;
    endcase
  end

  // Memory states either advance on ready, count another wait cycle, or trap once
  // the last allowed cycle passes without ready. The counter is zero on every entry.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    trap_d    = trap_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (memReady) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_FETCH_TO;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_DECODE: begin
        case (bus.op)
          OPC_LOAD, OPC_STORE:      state_d = S_MEMADR;
          OPC_OP, OPC_OP_IMM:       state_d = S_EXEC;
          OPC_OP_32, OPC_OP_IMM_32: if (SUPPORT_W) state_d = S_EXEC; else illegal = 1'b1;
          OPC_BRANCH:               state_d = S_BRANCH;
          OPC_JAL:                  state_d = S_JAL;
          OPC_JALR:                 state_d = S_JALR;
          OPC_LUI:                  state_d = S_LUI;
          OPC_AUIPC:                state_d = S_AUIPC;
          OPC_SYSTEM:               if (isEcall) state_d = S_FETCH; else illegal = 1'b1;
          default:                  illegal = 1'b1;
        endcase
        if (illegal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEMADR: state_d = (bus.op == OPC_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD, S_MEMWR: begin
        if (memReady) begin
          state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_DATA_TO;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_EXEC:  state_d = S_ALUWB;
      S_JALR:  state_d = S_JALR2;
      S_TRAP:  state_d = S_TRAP;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR2, S_LUI, S_AUIPC: state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      instret_d = instret_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Outputs decode from the state register; reset forces them low at once so an
  // in-flight memory request is withdrawn without waiting for a clock edge.
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.memWrite   = 1'b0;
    bus.memType    = 3'b000;
    bus.adrSrc     = 1'b0;
    bus.irWrite    = 1'b0;
    bus.pcWrite    = 1'b0;
    bus.regWrite   = 1'b0;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RS2;
    bus.ALUControl = ALU_ADD;
    bus.ALU32      = 1'b0;
    bus.immSrc     = IMM_I;
    bus.resultSrc  = RES_ALU;
    bus.ecall      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.memType = MEMTYPE_FETCH;
          bus.ALUSrcB = SRCB_FOUR;
          bus.irWrite = memReady;
          bus.pcWrite = memReady;
        end
        S_DECODE: begin
          bus.ALUSrcA = SRCA_OLDPC;
          bus.ALUSrcB = SRCB_IMM;
          bus.immSrc  = immType;
          bus.ecall   = isEcall;
        end
        S_MEMADR: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALUSrcB = SRCB_IMM;
          bus.immSrc  = immType;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.adrSrc  = 1'b1;
          bus.memType = bus.funct3;
        end
        S_MEMWB: begin
          bus.resultSrc = RES_MEM;
          bus.regWrite  = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.memWrite = 1'b1;
          bus.adrSrc   = 1'b1;
          bus.memType  = bus.funct3;
        end
        S_EXEC: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALU32   = isWOp;
          if (isImmOp) begin
            bus.ALUSrcB    = SRCB_IMM;
            bus.ALUControl = (bus.funct3 == 3'b101) ? {bus.funct7[5], bus.funct3}
                                                    : {1'b0, bus.funct3};
          end else begin
            bus.ALUSrcB    = SRCB_RS2;
            bus.ALUControl = {bus.funct7[5], bus.funct3};
          end
        end
        S_ALUWB: begin
          bus.resultSrc = RES_ALUOUT;
          bus.regWrite  = 1'b1;
        end
        S_BRANCH: begin
          bus.ALUSrcA    = SRCA_RS1;
          bus.ALUSrcB    = SRCB_RS2;
          bus.ALUControl = ALU_SUB;
          bus.pcWrite    = branchTaken;
          bus.resultSrc  = RES_ALUOUT;
        end
        S_JAL: begin
          bus.ALUSrcA  = SRCA_OLDPC;
          bus.ALUSrcB  = SRCB_FOUR;
          bus.regWrite = 1'b1;
          bus.pcWrite  = 1'b1;
        end
        S_JALR: begin
          bus.ALUSrcA  = SRCA_OLDPC;
          bus.ALUSrcB  = SRCB_FOUR;
          bus.regWrite = 1'b1;
        end
        S_JALR2: begin
          bus.ALUSrcA = SRCA_RS1;
          bus.ALUSrcB = SRCB_IMM;
          bus.immSrc  = IMM_I;
          bus.pcWrite = 1'b1;
        end
        S_LUI: begin
          bus.immSrc    = IMM_U;
          bus.resultSrc = RES_IMM;
          bus.regWrite  = 1'b1;
        end
        S_AUIPC: begin
          bus.ALUSrcA  = SRCA_OLDPC;
          bus.ALUSrcB  = SRCB_IMM;
          bus.immSrc   = IMM_U;
          bus.regWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_control_unit_multicycle.sv
// Directed bench for the multicycle control FSM: instance A uses the memory
// handshake with a short timeout, instance B runs without handshake, no *W ops, 3-bit instret.
module tb_control_unit_multicycle;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   expInstret  = 0;

  control_unit_multicycle_if #(.CNT_W(32)) busA ();
  control_unit_multicycle_if #(.CNT_W(3))  busB ();

  control_unit_multicycle #(
    .MEM_HANDSHAKE(1'b1),
    .MEM_TIMEOUT  (4),
    .SUPPORT_W    (1'b1),
    .CNT_W        (32)
  ) dutA (
    .clk  (clk),
    .reset(reset),
    .bus  (busA.master)
  );

  control_unit_multicycle #(
    .MEM_HANDSHAKE(1'b0),
    .MEM_TIMEOUT  (16),
    .SUPPORT_W    (1'b0),
    .CNT_W        (3)
  ) dutB (
    .clk  (clk),
    .reset(reset),
    .bus  (busB.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit toB, input logic [6:0] opV, input logic [2:0] f3,
                               input logic [6:0] f7, input logic rdy);
    if (toB) begin
      busB.op        = opV;
      busB.funct3    = f3;
      busB.funct7    = f7;
      busB.mem_ready = rdy;
    end else begin
      busA.op        = opV;
      busA.funct3    = f3;
      busA.funct7    = f7;
      busA.mem_ready = rdy;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0);
    applyStimulus(1'b1, 7'd0, 3'd0, 7'd0, 1'b0);
    busA.zero = 1'b0; busA.lt = 1'b0; busA.ltu = 1'b0;
    busB.zero = 1'b0; busB.lt = 1'b0; busB.ltu = 1'b0;

    @(negedge clk);
    checkOutput("A.rst.mem_req", busA.mem_req, 1'b0);
    checkOutput("A.rst.irWrite", busA.irWrite, 1'b0);
    checkOutput("A.rst.trap", busA.trap, 1'b0);
    checkOutput("A.rst.cause", busA.trap_cause, 2'b00);
    checkOutput("A.rst.instret", busA.instret, 32'd0);
    checkOutput("B.rst.mem_req", busB.mem_req, 1'b0);
    checkOutput("B.rst.instret", busB.instret, 3'd0);

    // B executes ADD without handshake while A starves in FETCH and times out.
    applyStimulus(1'b1, OPC_OP, 3'b000, 7'b0000000, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("A.f1.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.f1.memType", busA.memType, 3'b110);
    checkOutput("A.f1.irWrite", busA.irWrite, 1'b0);
    checkOutput("B.add.c1.irWrite", busB.irWrite, 1'b1);
    checkOutput("B.add.c1.pcWrite", busB.pcWrite, 1'b1);
    checkOutput("B.add.c1.regWrite", busB.regWrite, 1'b0);
    tick();
    checkOutput("B.add.c2.ALUSrcA", busB.ALUSrcA, 2'b01);
    checkOutput("B.add.c2.regWrite", busB.regWrite, 1'b0);
    tick();
    checkOutput("B.add.c3.ALUSrcA", busB.ALUSrcA, 2'b10);
    checkOutput("B.add.c3.ALUSrcB", busB.ALUSrcB, 2'b00);
    checkOutput("B.add.c3.ALUControl", busB.ALUControl, 4'b0000);
    checkOutput("B.add.c3.regWrite", busB.regWrite, 1'b0);
    tick();
    checkOutput("A.f4.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.f4.trap", busA.trap, 1'b0);
    checkOutput("B.add.c4.regWrite", busB.regWrite, 1'b1);
    checkOutput("B.add.c4.resultSrc", busB.resultSrc, 2'b01);
    checkOutput("B.add.c4.instret", busB.instret, 3'd0);
    applyStimulus(1'b1, OPC_SYSTEM, 3'b000, 7'd0, 1'b0);
    tick();
    checkOutput("A.fto.trap", busA.trap, 1'b1);
    checkOutput("A.fto.cause", busA.trap_cause, 2'b10);
    checkOutput("A.fto.mem_req", busA.mem_req, 1'b0);
    checkOutput("B.add.retire.instret", busB.instret, 3'd1);
    checkOutput("B.add.retire.regWrite", busB.regWrite, 1'b0);
    tick();
    checkOutput("B.ecall.pulse", busB.ecall, 1'b1);
    tick();
    checkOutput("B.ecall.done", busB.ecall, 1'b0);
    checkOutput("B.ecall.instret", busB.instret, 3'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      tick();
    end
    checkOutput("B.instret.wrap", busB.instret, 3'd0);
    checkOutput("A.fto.sticky.trap", busA.trap, 1'b1);
    checkOutput("A.fto.sticky.cause", busA.trap_cause, 2'b10);
    checkOutput("A.fto.sticky.mem_req", busA.mem_req, 1'b0);

    applyStimulus(1'b1, OPC_OP_32, 3'b000, 7'd0, 1'b0);
    tick();
    tick();
    checkOutput("B.op32.trap", busB.trap, 1'b1);
    checkOutput("B.op32.cause", busB.trap_cause, 2'b01);
    tick();
    checkOutput("B.op32.sticky", busB.trap, 1'b1);
    checkOutput("B.op32.mem_req", busB.mem_req, 1'b0);
    checkOutput("B.op32.instret", busB.instret, 3'd0);

    reset = 1'b1;
    #1;
    checkOutput("A.rst2.trap", busA.trap, 1'b0);
    checkOutput("A.rst2.cause", busA.trap_cause, 2'b00);
    @(negedge clk);

    // LW: data access answered on the fourth MEMRD cycle, the last one before timeout.
    applyStimulus(1'b0, OPC_LOAD, 3'b010, 7'd0, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("A.lw.fetch.irWrite", busA.irWrite, 1'b1);
    checkOutput("A.lw.fetch.pcWrite", busA.pcWrite, 1'b1);
    checkOutput("A.lw.fetch.ALUSrcB", busA.ALUSrcB, 2'b10);
    tick();
    busA.mem_ready = 1'b0;
    checkOutput("A.lw.dec.ALUSrcA", busA.ALUSrcA, 2'b01);
    checkOutput("A.lw.dec.ALUSrcB", busA.ALUSrcB, 2'b01);
    checkOutput("A.lw.dec.mem_req", busA.mem_req, 1'b0);
    tick();
    checkOutput("A.lw.adr.ALUSrcA", busA.ALUSrcA, 2'b10);
    checkOutput("A.lw.adr.immSrc", busA.immSrc, 3'd0);
    tick();
    checkOutput("A.lw.rd1.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.lw.rd1.adrSrc", busA.adrSrc, 1'b1);
    checkOutput("A.lw.rd1.memType", busA.memType, 3'b010);
    checkOutput("A.lw.rd1.memWrite", busA.memWrite, 1'b0);
    tick();
    checkOutput("A.lw.rd2.mem_req", busA.mem_req, 1'b1);
    tick();
    checkOutput("A.lw.rd3.mem_req", busA.mem_req, 1'b1);
    tick();
    checkOutput("A.lw.rd4.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.lw.rd4.regWrite", busA.regWrite, 1'b0);
    busA.mem_ready = 1'b1;
    tick();
    checkOutput("A.lw.wb.regWrite", busA.regWrite, 1'b1);
    checkOutput("A.lw.wb.resultSrc", busA.resultSrc, 2'b10);
    checkOutput("A.lw.wb.trap", busA.trap, 1'b0);
    tick();
    expInstret = 1;
    checkOutput("A.lw.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_BRANCH, 3'b001, 7'd0, 1'b1);
    busA.zero = 1'b1;
    tick();
    tick();
    checkOutput("A.bne.pcWrite", busA.pcWrite, 1'b0);
    checkOutput("A.bne.ALUControl", busA.ALUControl, 4'b1000);
    checkOutput("A.bne.ALUSrcA", busA.ALUSrcA, 2'b10);
    tick();
    expInstret++;
    checkOutput("A.bne.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_BRANCH, 3'b110, 7'd0, 1'b1);
    busA.zero = 1'b0;
    busA.ltu  = 1'b1;
    tick();
    tick();
    checkOutput("A.bltu.pcWrite", busA.pcWrite, 1'b1);
    checkOutput("A.bltu.resultSrc", busA.resultSrc, 2'b01);
    tick();
    expInstret++;
    checkOutput("A.bltu.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_OP_32, 3'b000, 7'b0000000, 1'b1);
    tick();
    tick();
    checkOutput("A.addw.ALU32", busA.ALU32, 1'b1);
    checkOutput("A.addw.ALUSrcB", busA.ALUSrcB, 2'b00);
    checkOutput("A.addw.ALUControl", busA.ALUControl, 4'b0000);
    tick();
    checkOutput("A.addw.wb.regWrite", busA.regWrite, 1'b1);
    checkOutput("A.addw.wb.ALU32", busA.ALU32, 1'b0);
    tick();
    expInstret++;

    applyStimulus(1'b0, OPC_OP_IMM, 3'b101, 7'b0100000, 1'b1);
    tick();
    tick();
    checkOutput("A.srai.ALUControl", busA.ALUControl, 4'b1101);
    checkOutput("A.srai.ALUSrcB", busA.ALUSrcB, 2'b01);
    checkOutput("A.srai.ALU32", busA.ALU32, 1'b0);
    tick();
    tick();
    expInstret++;

    applyStimulus(1'b0, OPC_OP_IMM, 3'b111, 7'b0100000, 1'b1);
    tick();
    tick();
    checkOutput("A.andi.ALUControl", busA.ALUControl, 4'b0111);
    tick();
    tick();
    expInstret++;

    applyStimulus(1'b0, OPC_OP, 3'b000, 7'b0100000, 1'b1);
    tick();
    tick();
    checkOutput("A.sub.ALUControl", busA.ALUControl, 4'b1000);
    tick();
    tick();
    expInstret++;
    checkOutput("A.alu.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_JAL, 3'b000, 7'd0, 1'b1);
    tick();
    checkOutput("A.jal.dec.immSrc", busA.immSrc, 3'd4);
    tick();
    checkOutput("A.jal.regWrite", busA.regWrite, 1'b1);
    checkOutput("A.jal.pcWrite", busA.pcWrite, 1'b1);
    checkOutput("A.jal.ALUSrcA", busA.ALUSrcA, 2'b01);
    checkOutput("A.jal.ALUSrcB", busA.ALUSrcB, 2'b10);
    tick();
    expInstret++;
    checkOutput("A.jal.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_JALR, 3'b000, 7'd0, 1'b1);
    tick();
    tick();
    checkOutput("A.jalr1.regWrite", busA.regWrite, 1'b1);
    checkOutput("A.jalr1.pcWrite", busA.pcWrite, 1'b0);
    tick();
    checkOutput("A.jalr2.pcWrite", busA.pcWrite, 1'b1);
    checkOutput("A.jalr2.regWrite", busA.regWrite, 1'b0);
    checkOutput("A.jalr2.ALUSrcA", busA.ALUSrcA, 2'b10);
    checkOutput("A.jalr2.ALUSrcB", busA.ALUSrcB, 2'b01);
    tick();
    expInstret++;
    checkOutput("A.jalr.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_LUI, 3'b000, 7'd0, 1'b1);
    tick();
    tick();
    checkOutput("A.lui.resultSrc", busA.resultSrc, 2'b11);
    checkOutput("A.lui.regWrite", busA.regWrite, 1'b1);
    tick();
    expInstret++;

    // SW answered on the last allowed wait cycle must complete without trapping.
    applyStimulus(1'b0, OPC_STORE, 3'b010, 7'd0, 1'b1);
    tick();
    busA.mem_ready = 1'b0;
    checkOutput("A.sw.dec.immSrc", busA.immSrc, 3'd1);
    tick();
    tick();
    checkOutput("A.sw.wr1.memWrite", busA.memWrite, 1'b1);
    checkOutput("A.sw.wr1.adrSrc", busA.adrSrc, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("A.sw.wr4.mem_req", busA.mem_req, 1'b1);
    busA.mem_ready = 1'b1;
    tick();
    expInstret++;
    checkOutput("A.sw.trap", busA.trap, 1'b0);
    checkOutput("A.sw.instret", busA.instret, 64'(expInstret));

    applyStimulus(1'b0, OPC_LOAD, 3'b011, 7'd0, 1'b1);
    tick();
    busA.mem_ready = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    checkOutput("A.dto.rd4.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.dto.rd4.memType", busA.memType, 3'b011);
    tick();
    checkOutput("A.dto.trap", busA.trap, 1'b1);
    checkOutput("A.dto.cause", busA.trap_cause, 2'b11);
    checkOutput("A.dto.mem_req", busA.mem_req, 1'b0);
    checkOutput("A.dto.instret", busA.instret, 64'(expInstret));

    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, OPC_STORE, 3'b000, 7'd0, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("A.swr.fetch.trap", busA.trap, 1'b0);
    tick();
    busA.mem_ready = 1'b0;
    tick();
    tick();
    checkOutput("A.swr.wr.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.swr.wr.memWrite", busA.memWrite, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("A.swr.async.mem_req", busA.mem_req, 1'b0);
    checkOutput("A.swr.async.memWrite", busA.memWrite, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("A.swr.after.mem_req", busA.mem_req, 1'b1);
    checkOutput("A.swr.after.memType", busA.memType, 3'b110);
    checkOutput("A.swr.after.memWrite", busA.memWrite, 1'b0);
    checkOutput("A.swr.after.instret", busA.instret, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
